if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage of the RV32 core. Generates word-aligned PCs toward the
//  instruction memory (valid/ready request, fixed 1-cycle response), buffers the
//  returned {pc,inst} pairs in a small FIFO, and presents them to decode via a
//  valid/ready handshake. Handles redirect (jump/branch) with flush of stale data.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC issued first after reset
//  FIFO_DEPTH  2              {pc,inst} buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  jump_en_i      in   1   redirect request from ex stage (1-cycle pulse)
//  jump_addr_i    in   32  redirect target; bits[1:0] ignored (forced 0)
//  pc_o           out  32  fetch address to inst memory
//  pc_valid_o     out  1   fetch request valid
//  pc_ready_i     in   1   memory accepts request this cycle
//  inst_i         in   32  instruction data from memory
//  inst_valid_i   in   1   response valid, exactly 1 cycle after accepted request
//  inst_o         out  32  instruction to decode (FIFO head)
//  inst_pc_o      out  32  PC of inst_o
//  inst_valid_o   out  1   FIFO non-empty
//  inst_ready_i   in   1   decode consumes head this cycle
// BEHAVIOUR
//  Reset (async): pc_q=RESET_PC, pc_valid_o=0, FIFO empty, inst_valid_o=0,
//   inst_o=0, inst_pc_o=0, inflight=0, epoch=0. pc_valid_o may rise first cycle after reset.
//  Request fire = pc_valid_o & pc_ready_i. On fire: pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC->0),
//   inflight<=1 with {pc,epoch} captured; else inflight<=0.
//  pc_valid_o = (count + inflight) < FIFO_DEPTH and !jump_en_i; guarantees every
//   response has a free slot - FIFO never overflows, responses never dropped for space.
//  Response: when inflight & inst_valid_i and captured epoch==current epoch, push
//   {captured pc, inst_i}. inst_valid_i without inflight is ignored.
//  Decode side: inst_o/inst_pc_o = FIFO head (registered storage, combinational read);
//   pop on inst_valid_o & inst_ready_i. inst_ready_i while empty: no effect.
//  Push and pop same cycle: count unchanged; push into empty FIFO visible next cycle
//   (no bypass; min latency request-fire -> inst_valid_o = 2 cycles).
//  Redirect (jump_en_i=1): pc_q<={jump_addr_i[31:2],2'b00}; FIFO cleared (count=0,
//   ptrs=0); epoch toggles; no request issued that cycle. Any response arriving next
//   cycle carries old epoch and is discarded. Redirect wins over simultaneous push/pop.
//  Unaccepted request (pc_valid_o & !pc_ready_i): pc_o held stable unless redirect.
//  Stall: memory may hold pc_ready_i low indefinitely; decode may hold inst_ready_i low
//   indefinitely; FIFO fills to FIFO_DEPTH then pc_valid_o=0 until a pop.
//  Reset mid-operation: immediate return to reset state; in-flight response ignored.
//  count width = $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1. Reset release, pc_ready_i=1, inst_ready_i=1 -> pc_o 0,4,8,..; decode sees
//     inst_pc_o 0,4,8 in order, first inst_valid_o 2 cycles after first fire.
//  2. inst_ready_i=0 -> FIFO holds 2 entries (pc 0,4), pc_valid_o drops, pc_o=8 held;
//     raise inst_ready_i -> fetch resumes from 8, no lost/duplicate PCs.
//  3. jump_en_i=1, jump_addr_i=32'h0000_0103 the cycle after fire of pc=8 -> pc=8 data
//     discarded, FIFO empty, next pc_o=32'h100, decode next sees inst_pc_o=32'h100.
//  4. pc_ready_i toggling 1/0 randomly -> pc_o stable while unaccepted; stream in order.
//  5. Redirect same cycle as decode pop with FIFO full -> FIFO empty next cycle, epoch
//     flip, no stale entry reaches decode.
//  6. Start RESET_PC=32'hFFFF_FFF8 -> pc_o FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word-aligned PCs to instruction memory, buffers
// {pc,inst} responses in a small FIFO and hands them to decode; redirects flush stale data.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    input  logic        pc_ready_i,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q;
    logic          run_q;
    logic          epoch_q;
    logic          inflight_q;
    logic          inflight_epoch_q;
    logic [31:0]   inflight_pc_q;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW:0]   occupancy;
    logic          fire;
    logic          push;
    logic          pop;

    // Count the in-flight request as occupied so every response is guaranteed a slot.
    assign occupancy    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign pc_valid_o   = run_q && !jump_en_i && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign pc_o         = pc_q;
    assign fire         = pc_valid_o && pc_ready_i;
    assign push         = inflight_q && inst_valid_i && (inflight_epoch_q == epoch_q);
    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = fifo_inst[rd_ptr_q];
    assign inst_pc_o    = fifo_pc[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            run_q            <= 1'b0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            inflight_q <= fire;
            if (fire) begin
                inflight_pc_q    <= pc_q;
                inflight_epoch_q <= epoch_q;
            end
            // Redirect overrides any push/pop in the same cycle.
            if (jump_en_i) begin
                pc_q     <= jump_addr_i & 32'hFFFF_FFFC;
                epoch_q  <= ~epoch_q;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    fifo_pc[wr_ptr_q]   <= inflight_pc_q;
                    fifo_inst[wr_ptr_q] <= inst_i;
                    wr_ptr_q            <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (!push && pop) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a 1-cycle memory model answers each fire with ~pc,
// and a decode monitor records every consumed {pc,inst} for order checks.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, jump_en_i, pc_ready_i, inst_valid_i, inst_ready_i;
    logic [31:0] jump_addr_i, inst_i, pc_o, inst_o, inst_pc_o;
    logic        pc_valid_o, inst_valid_o;

    logic        rst2_n, jump2_en_i, pc2_ready_i, inst2_valid_i, inst2_ready_i;
    logic [31:0] jump2_addr_i, inst2_i, pc2_o, inst2_o, inst2_pc_o;
    logic        pc2_valid_o, inst2_valid_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic [31:0] fired_pc[$];

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
        .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .jump_en_i(jump2_en_i), .jump_addr_i(jump2_addr_i),
        .pc_o(pc2_o), .pc_valid_o(pc2_valid_o), .pc_ready_i(pc2_ready_i),
        .inst_i(inst2_i), .inst_valid_i(inst2_valid_i),
        .inst_o(inst2_o), .inst_pc_o(inst2_pc_o), .inst_valid_o(inst2_valid_o),
        .inst_ready_i(inst2_ready_i)
    );

    // Memory model and decode monitor; samples pre-edge values at the clock edge.
    always @(posedge clk) begin : mem_model
        logic        f;
        logic [31:0] a;
        f = rst_n && pc_valid_o && pc_ready_i;
        a = pc_o;
        if (f) fired_pc.push_back(a);
        if (rst_n && inst_valid_o && inst_ready_i) begin
            got_pc.push_back(inst_pc_o);
            got_inst.push_back(inst_o);
        end
        #1;
        inst_valid_i = f;
        inst_i       = ~a;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        cyc();
        rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
        pc_ready_i = 1'b1; inst_ready_i = rdy;
        cyc();
        cyc();
        got_pc.delete(); got_inst.delete(); fired_pc.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_stream(input string name, input logic [31:0] base, input int n);
        checks++;
        if (got_pc.size() < n) begin
            errors++;
            $display("FAIL %s_len: got %0d entries, need at least %0d", name, got_pc.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++;
                if (got_pc[k] !== base + 32'(4 * k) || got_inst[k] !== ~(base + 32'(4 * k))) begin
                    errors++;
                    $display("FAIL %s[%0d]: pc=%h inst=%h, expected pc=%h inst=%h", name, k,
                             got_pc[k], got_inst[k], base + 32'(4 * k), ~(base + 32'(4 * k)));
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) cyc();
        rst_n = 1'b0;
        mid();
        checks++;
        if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || inst_valid_o !== 1'b0 ||
            inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: pc=%h pcv=%b iv=%b inst=%h ipc=%h, expected 0 0 0 0 0",
                     pc_o, pc_valid_o, inst_valid_o, inst_o, inst_pc_o);
        end
        checks++;
        if (pc2_o !== 32'hFFFF_FFF8 || pc2_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_param: pc=%h pcv=%b, expected fffffff8 0", pc2_o, pc2_valid_o);
        end
    endtask

    task automatic test_stream();
        int f_at = -1;
        int v_at = -1;
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            mid();
            if (f_at < 0 && pc_valid_o && pc_ready_i) f_at = i;
            if (v_at < 0 && inst_valid_o) v_at = i;
            cyc();
        end
        checks++;
        if (f_at < 0 || v_at - f_at != 2) begin
            errors++;
            $display("FAIL first_latency: fire at %0d valid at %0d, expected 2 cycles apart", f_at, v_at);
        end
        check_stream("stream", 32'h0, 8);
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) cyc();
        mid();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0 || inst_o !== 32'hFFFF_FFFF ||
            pc_valid_o !== 1'b0 || pc_o !== 32'h8 || fired_pc.size() != 2) begin
            errors++;
            $display("FAIL stall_full: iv=%b ipc=%h inst=%h pcv=%b pc=%h fired=%0d, expected 1 0 ffffffff 0 8 2",
                     inst_valid_o, inst_pc_o, inst_o, pc_valid_o, pc_o, fired_pc.size());
        end
        cyc();
        inst_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        check_stream("stall_resume", 32'h0, 8);
        for (int k = 0; k < fired_pc.size(); k++) begin
            checks++;
            if (fired_pc[k] !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stall_fired[%0d]: got %h, expected %h", k, fired_pc[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        do_reset(1'b1);
        for (int i = 0; i < 50 && !found; i++) begin
            mid();
            if (pc_o == 32'h8 && pc_valid_o && pc_ready_i) found = 1;
            else cyc();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_setup: fire of pc=8 not seen, got pc=%h", pc_o);
        end
        cyc();
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0103;
        mid();
        checks++;
        if (pc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_req: pcv=%b, expected 0", pc_valid_o);
        end
        cyc();
        jump_en_i = 1'b0;
        got_pc.delete(); got_inst.delete();
        mid();
        checks++;
        if (inst_valid_o !== 1'b0 || pc_o !== 32'h100) begin
            errors++;
            $display("FAIL redirect_flush: iv=%b pc=%h, expected 0 00000100", inst_valid_o, pc_o);
        end
        for (int i = 0; i < 20; i++) cyc();
        check_stream("redirect", 32'h100, 4);
    endtask

    task automatic test_random_ready();
        logic        held_v = 1'b0;
        logic [31:0] held_pc = '0;
        do_reset(1'b1);
        for (int i = 0; i < 60; i++) begin
            cyc();
            pc_ready_i = 1'($urandom_range(0, 1));
            mid();
            if (held_v) begin
                checks++;
                if (pc_o !== held_pc) begin
                    errors++;
                    $display("FAIL pc_hold: pc=%h, expected %h", pc_o, held_pc);
                end
            end
            held_v  = pc_valid_o && !pc_ready_i;
            held_pc = pc_o;
        end
        pc_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check_stream("random_ready", 32'h0, 6);
    endtask

    task automatic test_flush_full();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) cyc();
        mid();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: iv=%b pcv=%b, expected 1 0", inst_valid_o, pc_valid_o);
        end
        cyc();
        inst_ready_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
        cyc();
        jump_en_i = 1'b0;
        got_pc.delete(); got_inst.delete();
        mid();
        checks++;
        if (inst_valid_o !== 1'b0 || pc_o !== 32'h200) begin
            errors++;
            $display("FAIL flush_empty: iv=%b pc=%h, expected 0 00000200", inst_valid_o, pc_o);
        end
        for (int i = 0; i < 20; i++) cyc();
        check_stream("flush_full", 32'h200, 4);
    endtask

    task automatic test_wrap();
        logic [31:0] seq[$];
        cyc();
        rst2_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (pc2_valid_o) seq.push_back(pc2_o);
            cyc();
        end
        checks++;
        if (seq.size() < 3) begin
            errors++;
            $display("FAIL wrap_len: got %0d requests, need 3", seq.size());
        end else begin
            checks++;
            if (seq[0] !== 32'hFFFF_FFF8 || seq[1] !== 32'hFFFF_FFFC || seq[2] !== 32'h0) begin
                errors++;
                $display("FAIL wrap_seq: got %h %h %h, expected fffffff8 fffffffc 00000000",
                         seq[0], seq[1], seq[2]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; pc_ready_i = 1'b1;
        inst_ready_i = 1'b1; inst_valid_i = 1'b0; inst_i = '0;
        rst2_n = 1'b0; jump2_en_i = 1'b0; jump2_addr_i = '0; pc2_ready_i = 1'b1;
        inst2_valid_i = 1'b0; inst2_i = '0; inst2_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_random_ready();
        test_flush_full();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
